uart_fft_framer: RTL and testbench

Frame buffer and protocol sequencer between the UART byte link and the FFT core. It assembles POINTS little-endian samples from received bytes and streams them to the FFT core with a valid/ready handshake. It then captures OUT_WORDS result words from the core and serialises them back to the UART transmitter byte by byte. It sits in the top level between the UART receiver, the FFT datapath and the UART transmitter, and replaces direct byte wiring with a complete request/response frame engine.

---
 rtl/uart_fft_framer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_uart_fft_framer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fft_framer.sv
// uart_fft_framer: request/response frame engine between the UART byte link
// and the FFT core. Assembles POINTS little-endian samples from RX bytes,
// streams them to the core, captures OUT_WORDS results and serialises them
// to the UART transmitter, least-significant byte first.
// Optional feature macro: FRAMER_SYNC_EN (a frame starts only after sync
// byte 8'hA5; other bytes in S_IDLE are dropped silently).
//
// state     | meaning
// ----------+------------------------------------------------------
// S_IDLE    | waiting for the first byte of a frame
// S_RX      | assembling input words from received bytes
// S_FEED    | streaming buffered samples to the FFT core
// S_RESULT  | capturing result words from the FFT core
// S_TX      | presenting next result byte, strobing the transmitter
// S_TX_WAIT | waiting for the transmitter to finish the byte
module uart_fft_framer #(
  parameter int WORD_SIZE   = 16,
  parameter int DATA_LENGTH = 8,
  parameter int POINTS      = 16,
  parameter int OUT_WORDS   = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DATA_LENGTH-1:0] i_rx_byte,
  input  logic                   i_rx_valid,
  input  logic                   i_rx_error,
  output logic [WORD_SIZE-1:0]   o_sample,
  output logic                   o_sample_valid,
  input  logic                   i_sample_ready,
  input  logic [WORD_SIZE-1:0]   i_result,
  input  logic                   i_result_valid,
  output logic                   o_result_ready,
  output logic [DATA_LENGTH-1:0] o_tx_byte,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic                   o_frame_error,
  output logic                   o_overrun
);

  localparam int BPW = WORD_SIZE / DATA_LENGTH;
  localparam int BW  = $clog2(BPW + 1);
  localparam int PW  = $clog2(POINTS + 1);
  localparam int OW  = $clog2(OUT_WORDS + 1);
  // Buffer address widths; counters are one value wider so they never wrap.
  localparam int PIW = (POINTS > 1) ? $clog2(POINTS) : 1;
  localparam int OIW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_FEED, S_RESULT, S_TX, S_TX_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [BW-1:0] rx_byte_q, rx_byte_d;
  logic [PW-1:0] rx_word_q, rx_word_d;
  logic [PW-1:0] feed_idx_q, feed_idx_d;
  logic [OW-1:0] res_cnt_q, res_cnt_d;
  logic [BW-1:0] tx_byte_q, tx_byte_d;
  logic [OW-1:0] tx_word_q, tx_word_d;

  logic [WORD_SIZE-1:0]   sample_q, sample_d;
  logic                   sample_valid_q, sample_valid_d;
  logic                   result_ready_q, result_ready_d;
  logic [DATA_LENGTH-1:0] tx_out_q, tx_out_d;
  logic                   tx_start_q, tx_start_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic                   frame_error_q, frame_error_d;
  logic                   overrun_q, overrun_d;

  logic [WORD_SIZE-1:0] in_buf  [0:(1<<PIW)-1];
  logic [WORD_SIZE-1:0] out_buf [0:(1<<OIW)-1];

  logic                   in_wr, out_wr, rx_take;
  logic [WORD_SIZE-1:0]   wr_word, tx_word;
  logic [DATA_LENGTH-1:0] tx_sel;
  logic [PW-1:0]          feed_nxt;

  // Input word with the incoming byte merged into its lane.
  always_comb begin
    wr_word = in_buf[rx_word_q[PIW-1:0]];
    for (int b = 0; b < BPW; b++) begin
      if (rx_byte_q == BW'(b)) wr_word[b*DATA_LENGTH +: DATA_LENGTH] = i_rx_byte;
    end
  end

  // Byte lane of the current result word that goes out next.
  always_comb begin
    tx_word = out_buf[tx_word_q[OIW-1:0]];
    tx_sel  = '0;
    for (int b = 0; b < BPW; b++) begin
      if (tx_byte_q == BW'(b)) tx_sel = tx_word[b*DATA_LENGTH +: DATA_LENGTH];
    end
  end

  assign feed_nxt = feed_idx_q + 1'b1;

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d       = state_q;
    rx_byte_d     = rx_byte_q;
    rx_word_d     = rx_word_q;
    feed_idx_d    = feed_idx_q;
    res_cnt_d     = res_cnt_q;
    tx_byte_d     = tx_byte_q;
    tx_word_d     = tx_word_q;
    sample_d      = sample_q;
    tx_out_d      = tx_out_q;
    tx_start_d    = 1'b0;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;
    in_wr         = 1'b0;
    out_wr        = 1'b0;
    rx_take       = 1'b0;

    case (state_q)
      S_IDLE, S_RX: begin
        if (i_rx_error) begin
          // Error wins over a simultaneous byte; partial frame is dropped.
          frame_error_d = 1'b1;
          state_d       = S_IDLE;
        end else if (i_rx_valid) begin
`ifdef FRAMER_SYNC_EN
          if (state_q == S_RX) begin
            rx_take = 1'b1;
          end else if (i_rx_byte == DATA_LENGTH'(8'hA5)) begin
            state_d = S_RX;
          end
`else
          rx_take = 1'b1;
`endif
        end
      end
      S_FEED: begin
        if (i_sample_ready) begin
          feed_idx_d = feed_nxt;
          if (feed_idx_q == PW'(POINTS - 1)) state_d = S_RESULT;
          else sample_d = in_buf[feed_nxt[PIW-1:0]];
        end
      end
      S_RESULT: begin
        if (i_result_valid) begin
          out_wr    = 1'b1;
          res_cnt_d = res_cnt_q + 1'b1;
          if (res_cnt_q == OW'(OUT_WORDS - 1)) state_d = S_TX;
        end
      end
      S_TX: begin
        tx_out_d   = tx_sel;
        tx_start_d = 1'b1;
        state_d    = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (i_tx_done) begin
          if (tx_word_q == OW'(OUT_WORDS - 1) && tx_byte_q == BW'(BPW - 1)) begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_TX;
            if (tx_byte_q == BW'(BPW - 1)) begin
              tx_byte_d = '0;
              tx_word_d = tx_word_q + 1'b1;
            end else begin
              tx_byte_d = tx_byte_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rx_take) begin
      in_wr = 1'b1;
      if (rx_byte_q == BW'(BPW - 1)) begin
        rx_byte_d = '0;
        rx_word_d = rx_word_q + 1'b1;
      end else begin
        rx_byte_d = rx_byte_q + 1'b1;
      end
      if (rx_word_q == PW'(POINTS - 1) && rx_byte_q == BW'(BPW - 1)) begin
        state_d = S_FEED;
        // With a single-word frame, word 0 is still being written this edge.
        sample_d = (POINTS == 1) ? wr_word : in_buf['0];
      end else begin
        state_d = S_RX;
      end
    end

    if (i_rx_valid && state_q != S_IDLE && state_q != S_RX) overrun_d = 1'b1;

    if (state_d == S_IDLE) begin
      rx_byte_d  = '0;
      rx_word_d  = '0;
      feed_idx_d = '0;
      res_cnt_d  = '0;
      tx_byte_d  = '0;
      tx_word_d  = '0;
    end

    sample_valid_d = (state_d == S_FEED);
    result_ready_d = (state_d == S_RESULT);
    busy_d         = (state_d != S_IDLE);
  end

  // State, counters and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q        <= S_IDLE;
      rx_byte_q      <= '0;
      rx_word_q      <= '0;
      feed_idx_q     <= '0;
      res_cnt_q      <= '0;
      tx_byte_q      <= '0;
      tx_word_q      <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      result_ready_q <= 1'b0;
      tx_out_q       <= '0;
      tx_start_q     <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_error_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rx_byte_q      <= rx_byte_d;
      rx_word_q      <= rx_word_d;
      feed_idx_q     <= feed_idx_d;
      res_cnt_q      <= res_cnt_d;
      tx_byte_q      <= tx_byte_d;
      tx_word_q      <= tx_word_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      result_ready_q <= result_ready_d;
      tx_out_q       <= tx_out_d;
      tx_start_q     <= tx_start_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      frame_error_q  <= frame_error_d;
      overrun_q      <= overrun_d;
    end
  end

  // Frame buffers carry data only, so they are not reset.
  always_ff @(posedge i_clk) begin
    if (in_wr)  in_buf[rx_word_q[PIW-1:0]]  <= wr_word;
    if (out_wr) out_buf[res_cnt_q[OIW-1:0]] <= i_result;
  end

  assign o_sample       = sample_q;
  assign o_sample_valid = sample_valid_q;
  assign o_result_ready = result_ready_q;
  assign o_tx_byte      = tx_out_q;
  assign o_tx_start     = tx_start_q;
  assign o_busy         = busy_q;
  assign o_frame_done   = frame_done_q;
  assign o_frame_error  = frame_error_q;
  assign o_overrun      = overrun_q;

endmodule

// File: tb/tb_uart_fft_framer.sv
// Scoreboard bench for uart_fft_framer: expected samples and TX bytes are
// queued as stimulus is issued and checked by independent monitors.
module tb_uart_fft_framer;
  localparam int WS = 16;
  localparam int DL = 8;
  localparam int NP = 16;
  localparam int NO = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DL-1:0] rx_byte = '0;
  logic          rx_valid = 1'b0;
  logic          rx_error = 1'b0;
  logic [WS-1:0] sample;
  logic          sample_valid;
  logic          sample_ready = 1'b0;
  logic [WS-1:0] result = '0;
  logic          result_valid = 1'b0;
  logic          result_ready;
  logic [DL-1:0] tx_byte;
  logic          tx_start;
  logic          tx_done = 1'b0;
  logic          busy, frame_done, frame_error, overrun;

  always #5 clk = ~clk;

  uart_fft_framer #(.WORD_SIZE(WS), .DATA_LENGTH(DL), .POINTS(NP), .OUT_WORDS(NO)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_rx_byte(rx_byte), .i_rx_valid(rx_valid), .i_rx_error(rx_error),
    .o_sample(sample), .o_sample_valid(sample_valid), .i_sample_ready(sample_ready),
    .i_result(result), .i_result_valid(result_valid), .o_result_ready(result_ready),
    .o_tx_byte(tx_byte), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_busy(busy), .o_frame_done(frame_done), .o_frame_error(frame_error),
    .o_overrun(overrun)
  );

  int tests = 0;
  int fails = 0;
  logic [WS-1:0] samp_q[$];
  logic [DL-1:0] tx_q[$];
  int cyc = 0;
  int xfers = 0, first_x = 0, last_x = 0;
  int done_cnt = 0, err_cnt = 0, ovr_cnt = 0, tx_dones = 0, gen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters.
  always @(negedge clk) begin
    if (frame_done)  done_cnt++;
    if (frame_error) err_cnt++;
    if (overrun)     ovr_cnt++;
  end

  // Sample monitor: presented sample must match queue head, even when stalled.
  always @(negedge clk) begin
    if (rst_n && sample_valid) begin
      if (samp_q.size() == 0) chk("sample_extra", 1, 0);
      else begin
        chk("sample", sample, samp_q[0]);
        if (sample_ready) begin
          void'(samp_q.pop_front());
          if (xfers == 0) first_x = cyc;
          last_x = cyc;
          xfers++;
        end
      end
    end
  end

  // Transmitter model: checks each started byte and answers with tx_done.
  initial begin : tx_model
    int g;
    logic [DL-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        g = gen;
        if (tx_q.size() == 0) begin
          chk("tx_extra", 1, 0);
          e = 'x;
        end else begin
          e = tx_q.pop_front();
          chk("tx_byte", tx_byte, e);
        end
        repeat (2) @(posedge clk);
        #1 tx_done = 1'b1;
        @(negedge clk);
        if (g == gen) chk("tx_hold", tx_byte, e);
        @(posedge clk);
        #1 tx_done = 1'b0;
        tx_dones++;
      end
    end
  end

  task automatic send_byte(input logic [DL-1:0] b, input logic v, input logic err);
    @(posedge clk); #1;
    rx_byte = b; rx_valid = v; rx_error = err;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_error = 1'b0;
  endtask

  task automatic send_frame(input logic [WS-1:0] w0, input logic [WS-1:0] step);
    logic [WS-1:0] w;
`ifdef FRAMER_SYNC_EN
    send_byte(8'hA5, 1'b1, 1'b0);
`endif
    for (int i = 0; i < NP; i++) begin
      w = w0 + WS'(i) * step;
      samp_q.push_back(w);
      send_byte(w[7:0], 1'b1, 1'b0);
      if (i == NP - 1) chk("valid_before_last", sample_valid, 0);
      send_byte(w[15:8], 1'b1, 1'b0);
    end
    chk("valid_rise", sample_valid, 1);
  endtask

  task automatic wait_feed();
    for (int i = 0; i < 300 && samp_q.size() != 0; i++) @(negedge clk);
    chk("feed_complete", samp_q.size(), 0);
  endtask

  task automatic send_results(input logic [WS-1:0] base, input logic inj);
    logic [WS-1:0] r;
    for (int i = 0; i < 200 && !result_ready; i++) @(negedge clk);
    chk("result_ready", result_ready, 1);
    for (int k = 0; k < NO; k++) begin
      @(posedge clk); #1;
      r = base + WS'(k);
      result = r; result_valid = 1'b1;
      tx_q.push_back(r[7:0]);
      tx_q.push_back(r[15:8]);
      rx_byte = 8'hEE;
      rx_valid = inj && (k == 5);
    end
    @(posedge clk); #1;
    result_valid = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && done_cnt < target; i++) @(negedge clk);
    chk("frame_done_cnt", done_cnt, target);
    chk("tx_queue_drained", tx_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_sample", sample, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_result_ready", result_ready, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_overrun", overrun, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst_n = 1'b1;

    // Nominal frame with ready held high.
    sample_ready = 1'b1;
    xfers = 0;
    send_frame(16'h0001, 16'h0001);
    wait_feed();
    chk("nominal_xfers", xfers, NP);
    chk("nominal_span", last_x - first_x, NP - 1);
    send_results(16'h1000, 1'b0);
    wait_done(1);
    chk("nominal_overrun", ovr_cnt, 0);
    chk("nominal_frame_err", err_cnt, 0);
    chk("idle_busy", busy, 0);

    // Backpressure: 5 stalled cycles, then ready toggles every cycle.
    sample_ready = 1'b0;
    xfers = 0;
    send_frame(16'hC3A0, 16'h0111);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 200 && samp_q.size() != 0; i++) begin
      sample_ready = ~sample_ready;
      @(posedge clk); #1;
    end
    chk("bp_xfers", xfers, NP);
    sample_ready = 1'b1;
    send_results(16'h2200, 1'b0);
    wait_done(2);

    // RX error after 7 bytes; error coincides with a byte and must win.
`ifdef FRAMER_SYNC_EN
    send_byte(8'hA5, 1'b1, 1'b0);
`endif
    for (int i = 0; i < 7; i++) send_byte(8'h40 + 8'(i), 1'b1, 1'b0);
    send_byte(8'h77, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("frame_error_cnt", err_cnt, 1);
    chk("err_busy", busy, 0);
    send_frame(16'h5A01, 16'h0203);
    wait_feed();

    // Overrun injected during result capture.
    send_results(16'h3300, 1'b1);
    wait_done(3);
    chk("overrun_cnt", ovr_cnt, 1);
    chk("err_after_overrun", err_cnt, 1);

    // Reset during transmission, then a clean frame.
    send_frame(16'h0F00, 16'h0010);
    wait_feed();
    send_results(16'h4400, 1'b0);
    for (int i = 0; i < 2000 && tx_dones < 10 + 3 * 2 * NO; i++) @(negedge clk);
    chk("tx_before_reset", tx_dones, 10 + 3 * 2 * NO);
    rst_n = 1'b0;
    #1 check_reset_outputs();
    gen++;
    samp_q.delete();
    tx_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("done_after_reset", done_cnt, 3);
    send_frame(16'h8001, 16'h0101);
    wait_feed();
    send_results(16'h5500, 1'b0);
    wait_done(4);

`ifdef FRAMER_SYNC_EN
    // Non-sync byte in idle is dropped silently.
    send_byte(8'h3C, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("sync_no_overrun", ovr_cnt, 1);
    chk("sync_idle_busy", busy, 0);
    send_frame(16'h6101, 16'h0001);
    wait_feed();
    send_results(16'h6600, 1'b0);
    wait_done(5);
`endif

    chk("final_frame_err", err_cnt, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
